// File: rtl/ttest_hls_deadlock_reporter.sv
// Confirms a persistent dataflow deadlock, snapshots the blocked/idle process state
// and streams a 3-word report to the trace collector; keeps sticky flag and counters.
module ttest_hls_deadlock_reporter #(
  parameter int unsigned CONFIRM_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        block,
  input  logic [1:0]  axis_block_sigs,
  input  logic [9:0]  inst_idle_sigs,
  input  logic [6:0]  inst_block_sigs,
  input  logic        clear,
  output logic [31:0] rpt_data,
  output logic        rpt_valid,
  input  logic        rpt_ready,
  output logic        rpt_last,
  output logic        deadlock_flag,
  output logic [7:0]  deadlock_count,
  output logic [7:0]  spurious_count
);

  typedef enum logic [1:0] {S_IDLE, S_CONFIRM, S_SEND, S_HOLD} state_t;

  localparam logic [7:0] CONFIRM_N = 8'(CONFIRM_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  ccnt_q, ccnt_d;
  logic [31:0] ts_q, ts_d;
  logic [1:0]  idx_q, idx_d;
  logic        flag_q, flag_d;
  logic [7:0]  dl_cnt_q, dl_cnt_d;
  logic [7:0]  sp_cnt_q, sp_cnt_d;
  logic [31:0] ts_cap_q, ts_cap_d;
  logic [1:0]  axis_cap_q, axis_cap_d;
  logic [9:0]  idle_cap_q, idle_cap_d;
  logic [6:0]  blk_cap_q, blk_cap_d;
  logic [7:0]  dl_cap_q, dl_cap_d;
  logic [7:0]  sp_cap_q, sp_cap_d;
  logic        confirm;
  logic        spurious;
  logic [7:0]  dl_base;
  logic [7:0]  sp_base;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d    = state_q;
    ccnt_d     = ccnt_q;
    ts_d       = ts_q + 32'd1;
    idx_d      = idx_q;
    ts_cap_d   = ts_cap_q;
    axis_cap_d = axis_cap_q;
    idle_cap_d = idle_cap_q;
    blk_cap_d  = blk_cap_q;
    dl_cap_d   = dl_cap_q;
    sp_cap_d   = sp_cap_q;
    confirm    = 1'b0;
    spurious   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (block) begin
          if (CONFIRM_N == 8'd1) begin
            confirm = 1'b1;
          end else begin
            ccnt_d  = 8'd1;
            state_d = S_CONFIRM;
          end
        end
      end
      S_CONFIRM: begin
        if (!block) begin
          spurious = 1'b1;
          ccnt_d   = 8'd0;
          state_d  = S_IDLE;
        end else if (ccnt_q + 8'd1 == CONFIRM_N) begin
          confirm = 1'b1;
        end else begin
          ccnt_d = ccnt_q + 8'd1;
        end
      end
      S_SEND: begin
        if (rpt_ready) begin
          if (idx_q == 2'd2) begin
            idx_d   = 2'd0;
            state_d = S_HOLD;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_HOLD: begin
        if (!block) begin
          ccnt_d  = 8'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // clear zeroes the counters first; a same-cycle confirm then counts on top of it
    dl_base  = clear ? 8'd0 : dl_cnt_q;
    sp_base  = clear ? 8'd0 : sp_cnt_q;
    flag_d   = clear ? 1'b0 : flag_q;
    dl_cnt_d = dl_base;
    sp_cnt_d = sp_base;
    if (spurious && !clear) sp_cnt_d = sat_inc(sp_cnt_q);

    if (confirm) begin
      state_d    = S_SEND;
      idx_d      = 2'd0;
      ccnt_d     = 8'd0;
      flag_d     = 1'b1;
      dl_cnt_d   = sat_inc(dl_base);
      dl_cap_d   = sat_inc(dl_base);
      sp_cap_d   = sp_base;
      ts_cap_d   = ts_q;
      axis_cap_d = axis_block_sigs;
      idle_cap_d = inst_idle_sigs;
      blk_cap_d  = inst_block_sigs;
    end
  end

  always_comb begin
    rpt_valid = (state_q == S_SEND);
    rpt_last  = rpt_valid && (idx_q == 2'd2);
    rpt_data  = 32'd0;
    if (rpt_valid) begin
      case (idx_q)
        2'd0:    rpt_data = ts_cap_q;
        2'd1:    rpt_data = {8'hD1, 5'b0, axis_cap_q, blk_cap_q, idle_cap_q};
        2'd2:    rpt_data = {16'h0000, sp_cap_q, dl_cap_q};
        default: rpt_data = 32'd0;
      endcase
    end
    deadlock_flag  = flag_q;
    deadlock_count = dl_cnt_q;
    spurious_count = sp_cnt_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ccnt_q   <= 8'd0;
      ts_q     <= 32'd0;
      idx_q    <= 2'd0;
      flag_q   <= 1'b0;
      dl_cnt_q <= 8'd0;
      sp_cnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      ccnt_q   <= ccnt_d;
      ts_q     <= ts_d;
      idx_q    <= idx_d;
      flag_q   <= flag_d;
      dl_cnt_q <= dl_cnt_d;
      sp_cnt_q <= sp_cnt_d;
    end
  end

  // Snapshot registers only matter while in SEND, so they carry no reset
  always_ff @(posedge clock) begin
    ts_cap_q   <= ts_cap_d;
    axis_cap_q <= axis_cap_d;
    idle_cap_q <= idle_cap_d;
    blk_cap_q  <= blk_cap_d;
    dl_cap_q   <= dl_cap_d;
    sp_cap_q   <= sp_cap_d;
  end

endmodule
